// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and rise-to-rise period of an incoming PWM waveform,
// derives the duty code with a restoring divider and flags an input that has stopped toggling.
`default_nettype none

module pwm_duty_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int DUTY_W      = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              stuck,
   output logic              stuck_level,
   output logic              drop
);

   localparam logic [1:0]       S_ACQ   = 2'd0;
   localparam logic [1:0]       S_HIGH  = 2'd1;
   localparam logic [1:0]       S_LOW   = 2'd2;
   localparam int               IT_W    = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(DUTY_W + 1);
   localparam logic [IT_W-1:0]  IT_LAST = IT_W'(DUTY_W - 1);

   // ---------------- input synchronizer and edge detector ----------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   lvl_q;
   logic                   lvl;
   logic                   armed;
   logic                   rise;
   logic                   fall;
   logic                   edge_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         fill_q <= '0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         lvl_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edges are ignored until the pipeline holds real samples, so an input that is
   // already high when reset releases does not look like a fresh rise.
   assign lvl      = sync_q[SYNC_STAGES-1];
   assign armed    = fill_q[SYNC_STAGES];
   assign rise     = armed &  lvl & ~lvl_q;
   assign fall     = armed & ~lvl &  lvl_q;
   assign edge_any = rise | fall;

   // ---------------- edge timeout ----------------
   logic [CNT_W-1:0] tmo_q;
   logic [CNT_W-1:0] tmo_d;
   logic             tmo_hit;

   always_comb begin
      tmo_d = tmo_q;
      if (edge_any) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_LIM) begin
         tmo_d = tmo_q + CNT_W'(1);
      end
   end

   assign tmo_hit = ~edge_any & (tmo_q == TMO_LIM - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   // ---------------- measurement FSM ----------------
   logic [1:0] state_q;
   logic [1:0] state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ACQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = S_ACQ;
      end else begin
         case (state_q)
            S_ACQ:   if (rise) state_d = S_HIGH;
            S_HIGH:  if (fall) state_d = S_LOW;
            S_LOW:   if (rise) state_d = S_HIGH;
            default: state_d = S_ACQ;
         endcase
      end
   end

   logic busy_q;
   logic restart;
   logic complete;
   logic start;
   logic drop_now;
   logic in_high;
   logic in_low;

   always_comb begin
      restart  = 1'b0;
      complete = 1'b0;
      in_high  = 1'b0;
      in_low   = 1'b0;
      if (!tmo_hit) begin
         case (state_q)
            S_ACQ:  restart = rise;
            S_HIGH: in_high = 1'b1;
            S_LOW: begin
               in_low   = ~rise;
               restart  = rise;
               complete = rise;
            end
            default: ;
         endcase
      end
   end

   logic [CNT_W-1:0] hi_q;
   logic [CNT_W-1:0] hi_d;
   logic [CNT_W-1:0] per_q;
   logic [CNT_W-1:0] per_d;

   // Too-short periods are rejected outright so a fast burst never reaches the outputs.
   assign start    = complete & ~busy_q & (per_q >= MIN_PER);
   assign drop_now = complete & ~start;

   always_comb begin
      hi_d  = hi_q;
      per_d = per_q;
      if (tmo_hit) begin
         hi_d  = '0;
         per_d = '0;
      end else if (restart) begin
         hi_d  = CNT_W'(1);
         per_d = CNT_W'(1);
      end else if (in_high) begin
         per_d = (per_q == CNT_MAX) ? per_q : per_q + CNT_W'(1);
         if (!fall) begin
            hi_d = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_W'(1);
         end
      end else if (in_low) begin
         per_d = (per_q == CNT_MAX) ? per_q : per_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= '0;
         per_q <= '0;
      end else begin
         hi_q  <= hi_d;
         per_q <= per_d;
      end
   end

   // ---------------- restoring divider ----------------
   logic [IT_W-1:0]   iter_q;
   logic [CNT_W:0]    rem_q;
   logic [CNT_W-1:0]  den_q;
   logic [DUTY_W-1:0] quo_q;
   logic [CNT_W-1:0]  hi_n_q;
   logic [CNT_W-1:0]  per_n_q;
   logic [CNT_W:0]    rem_sh;
   logic              rem_ge;
   logic [CNT_W:0]    rem_nx;
   logic [DUTY_W-1:0] quo_nx;
   logic              div_last;

   assign rem_sh   = {rem_q[CNT_W-1:0], 1'b0};
   assign rem_ge   = rem_sh >= {1'b0, den_q};
   assign rem_nx   = rem_ge ? rem_sh - {1'b0, den_q} : rem_sh;
   assign quo_nx   = {quo_q[DUTY_W-2:0], rem_ge};
   assign div_last = busy_q & (iter_q == IT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         iter_q  <= '0;
         rem_q   <= '0;
         den_q   <= '0;
         quo_q   <= '0;
         hi_n_q  <= '0;
         per_n_q <= '0;
      end else if (tmo_hit) begin
         busy_q <= 1'b0;
      end else if (start) begin
         busy_q  <= 1'b1;
         iter_q  <= '0;
         rem_q   <= {1'b0, hi_q};
         den_q   <= per_q;
         quo_q   <= '0;
         hi_n_q  <= hi_q;
         per_n_q <= per_q;
      end else if (busy_q) begin
         rem_q  <= rem_nx;
         quo_q  <= quo_nx;
         iter_q <= iter_q + IT_W'(1);
         if (div_last) begin
            busy_q <= 1'b0;
         end
      end
   end

   // ---------------- output registers ----------------
   logic [DUTY_W-1:0] duty_q;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  high_q;
   logic              valid_q;
   logic              stuck_q;
   logic              stuck_lvl_q;
   logic              drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q      <= '0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         drop_q  <= drop_now;
         if (tmo_hit) begin
            stuck_q     <= 1'b1;
            stuck_lvl_q <= lvl;
            duty_q      <= {DUTY_W{lvl}};
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b1;
         end else begin
            if (edge_any && stuck_q) begin
               stuck_q     <= 1'b0;
               stuck_lvl_q <= 1'b0;
            end
            if (div_last) begin
               duty_q   <= quo_nx;
               period_q <= per_n_q;
               high_q   <= hi_n_q;
               valid_q  <= 1'b1;
            end
         end
      end
   end

   assign duty        = duty_q;
   assign period      = period_q;
   assign high_time   = high_q;
   assign valid       = valid_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuck_lvl_q;
   assign drop        = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed PWM waveforms with hand-computed duty, period and timing expectations.
`default_nettype none

module tb_pwm_duty_decoder;

   logic        clk;
   logic        rst;
   logic        pwm_in;
   logic [7:0]  duty;
   logic [15:0] period;
   logic [15:0] high_time;
   logic        valid;
   logic        stuck;
   logic        stuck_level;
   logic        drop;

   int n_tests;
   int n_fail;
   int cyc;
   int rise_cyc;
   int n_valid;
   int n_drop;
   int lat;

   pwm_duty_decoder #(
      .SYNC_STAGES(2),
      .CNT_W      (16),
      .DUTY_W     (8),
      .TIMEOUT    (1024)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .period     (period),
      .high_time  (high_time),
      .valid      (valid),
      .stuck      (stuck),
      .stuck_level(stuck_level),
      .drop       (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         n_valid = n_valid + 1;
         lat     = cyc - rise_cyc;
      end
      if (drop) n_drop = n_drop + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests = n_tests + 1;
      if (obs !== exp_v) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drives n periods of hi clocks high followed by per-hi clocks low; entered and left at posedge+1.
   task automatic gen(input int hi, input int per, input int n);
      for (int p = 0; p < n; p++) begin
         pwm_in   = 1'b1;
         rise_cyc = cyc;
         repeat (hi) @(posedge clk);
         #1;
         pwm_in = 1'b0;
         repeat (per - hi) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      rise_cyc = 0;
      n_valid  = 0;
      n_drop   = 0;
      lat      = 0;
      rst      = 1'b1;
      pwm_in   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_duty",   32'(duty),        32'd0);
      check("rst_period", 32'(period),      32'd0);
      check("rst_high",   32'(high_time),   32'd0);
      check("rst_valid",  32'(valid),       32'd0);
      check("rst_stuck",  32'(stuck),       32'd0);
      check("rst_slvl",   32'(stuck_level), 32'd0);
      check("rst_drop",   32'(drop),        32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // D=128
      n_valid = 0;
      gen(128, 256, 4);
      check("d128_duty",   32'(duty),      32'd128);
      check("d128_period", 32'(period),    32'd256);
      check("d128_high",   32'(high_time), 32'd128);
      check("d128_nvalid", 32'(n_valid),   32'd3);
      check("d128_lat",    32'(lat),       32'd11);
      check("d128_ndrop",  32'(n_drop),    32'd0);

      // D=200 after one transitional sample
      gen(200, 256, 3);
      check("d200_duty",   32'(duty),      32'd200);
      check("d200_period", 32'(period),    32'd256);
      check("d200_high",   32'(high_time), 32'd200);

      // D=50 with latency
      gen(50, 256, 3);
      check("d50_duty", 32'(duty),      32'd50);
      check("d50_high", 32'(high_time), 32'd50);
      check("d50_lat",  32'(lat),       32'd11);

      // stuck low
      n_valid = 0;
      repeat (1100) @(posedge clk);
      @(negedge clk);
      check("stk0_stuck",  32'(stuck),       32'd1);
      check("stk0_slvl",   32'(stuck_level), 32'd0);
      check("stk0_duty",   32'(duty),        32'd0);
      check("stk0_period", 32'(period),      32'd0);
      check("stk0_high",   32'(high_time),   32'd0);
      check("stk0_nvalid", 32'(n_valid),     32'd1);

      // stuck high
      @(posedge clk);
      #1 pwm_in = 1'b1;
      n_valid   = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("stk_clear_rise", 32'(stuck), 32'd0);
      repeat (1100) @(posedge clk);
      @(negedge clk);
      check("stk1_stuck",  32'(stuck),       32'd1);
      check("stk1_slvl",   32'(stuck_level), 32'd1);
      check("stk1_duty",   32'(duty),        32'd255);
      check("stk1_nvalid", 32'(n_valid),     32'd1);

      // resume D=50
      @(posedge clk);
      #1;
      n_valid = 0;
      gen(50, 256, 3);
      check("res_stuck",  32'(stuck),     32'd0);
      check("res_duty",   32'(duty),      32'd50);
      check("res_period", 32'(period),    32'd256);
      check("res_high",   32'(high_time), 32'd50);
      check("res_nvalid", 32'(n_valid),   32'd1);

      // short-period burst
      gen(3, 6, 4);
      n_valid = 0;
      n_drop  = 0;
      gen(3, 6, 30);
      check("burst_nvalid", 32'(n_valid), 32'd0);
      check("burst_ndrop",  32'(n_drop),  32'd30);
      check("burst_duty",   32'(duty),    32'd50);
      check("burst_period", 32'(period),  32'd256);

      // reset mid-HIGH
      gen(128, 256, 3);
      check("pre_rst_duty", 32'(duty), 32'd128);
      pwm_in = 1'b1;
      repeat (60) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      n_valid = 0;
      @(negedge clk);
      check("mrst_duty",   32'(duty),      32'd0);
      check("mrst_period", 32'(period),    32'd0);
      check("mrst_high",   32'(high_time), 32'd0);
      @(posedge clk);
      #1;
      repeat (66) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (128) @(posedge clk);
      #1;
      gen(128, 256, 1);
      check("mrst_noval", 32'(n_valid), 32'd0);
      gen(128, 256, 2);
      check("mrst_nvalid", 32'(n_valid), 32'd2);
      check("mrst_duty2",  32'(duty),    32'd128);
      check("mrst_per2",   32'(period),  32'd256);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
